// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
//  inst_fetch_if
//  ROM fetch bus, ID handoff and redirect signals of the instruction fetch unit.
//  Rev 1.0
// ============================================================================
interface inst_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

  logic                  rom_ce_o;
  logic [ADDR_WIDTH-1:0] rom_addr_o;
  logic [DATA_WIDTH-1:0] rom_inst_i;
  logic                  id_ready_i;
  logic                  id_valid_o;
  logic [ADDR_WIDTH-1:0] id_pc_o;
  logic [DATA_WIDTH-1:0] id_inst_o;
  logic                  branch_flag_i;
  logic [ADDR_WIDTH-1:0] branch_target_i;
  logic                  flush_i;
  logic [ADDR_WIDTH-1:0] new_pc_i;
  logic [CNT_WIDTH-1:0]  count_o;

  modport master (
    output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, count_o,
    input  rom_inst_i, id_ready_i, branch_flag_i, branch_target_i, flush_i, new_pc_i
  );

  modport slave (
    input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, count_o,
    output rom_inst_i, id_ready_i, branch_flag_i, branch_target_i, flush_i, new_pc_i
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  inst_fetch
//  Instruction fetch front end: drives the ROM, queues {pc, inst} pairs and
//  hands them to ID over valid/ready; branch/exception redirects flush it.
//  Rev 1.0
// ============================================================================
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  wire             clk,
  input  wire             rst,
  inst_fetch_if.master    bus
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] c_pc_step  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] c_align    = ~ADDR_WIDTH'(3);
  localparam logic [c_cnt_w-1:0]    c_full_cnt = c_cnt_w'(DEPTH);

  logic                  r_ce;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_cnt_w-1:0]    r_count;
  logic [ADDR_WIDTH-1:0] r_mem_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_inst [DEPTH];

  logic                  w_pop;
  logic                  w_redirect;
  logic                  w_full;
  logic                  w_fetch;
  logic                  w_empty;
  logic [ADDR_WIDTH-1:0] w_redirect_pc;

  always_comb begin
    w_empty       = (r_count == '0);
    w_full        = (r_count == c_full_cnt);
    w_pop         = ~w_empty & bus.id_ready_i;
    w_redirect    = bus.flush_i | bus.branch_flag_i;
    w_fetch       = r_ce & ~w_redirect & (~w_full | w_pop);
    // Exception redirect outranks a branch; targets are word-aligned by masking.
    w_redirect_pc = (bus.flush_i ? bus.new_pc_i : bus.branch_target_i) & c_align;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ce     <= 1'b0;
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_ce <= 1'b1;
      if (w_redirect) begin
        r_pc     <= w_redirect_pc;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_fetch) begin
          r_pc     <= r_pc + c_pc_step;
          r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
        case ({w_fetch, w_pop})
          2'b10:   r_count <= r_count + c_cnt_w'(1);
          2'b01:   r_count <= r_count - c_cnt_w'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Queue storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_fetch) begin
      r_mem_pc[r_wr_ptr]   <= r_pc;
      r_mem_inst[r_wr_ptr] <= bus.rom_inst_i;
    end
  end

  assign bus.rom_ce_o   = r_ce;
  assign bus.rom_addr_o = r_pc;
  assign bus.id_valid_o = ~w_empty;
  assign bus.id_pc_o    = w_empty ? '0 : r_mem_pc[r_rd_ptr];
  assign bus.id_inst_o  = w_empty ? '0 : r_mem_inst[r_rd_ptr];
  assign bus.count_o    = r_count;

endmodule
`default_nettype wire
